fp16_acc_pipe: RTL and testbench

//  Downstream consumer of the pipelined FP16 multiplier: accumulates a stream of FP16

---
 rtl/fp16_acc_pipe_if.sv | 24 ++
 rtl/fp16_acc_pipe.sv | 165 ++++++++++++++++
 tb/tb_fp16_acc_pipe.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_acc_pipe_if.sv
// Handshake/result bundle between an FP16 product source and fp16_acc_pipe.
// The source side drives clear/valid/product; the accumulator side returns ready, result and status.
interface fp16_acc_pipe_if #(
    parameter int CNT_W = 8
);
    logic             clear_59;
    logic             in_valid_59;
    logic             in_ready_59;
    logic [15:0]      prod_59;
    logic [15:0]      acc_result_59;
    logic             acc_valid_59;
    logic [CNT_W-1:0] term_cnt_59;
    logic             done_59;

    modport master (
        output clear_59, in_valid_59, prod_59,
        input  in_ready_59, acc_result_59, acc_valid_59, term_cnt_59, done_59
    );

    modport slave (
        input  clear_59, in_valid_59, prod_59,
        output in_ready_59, acc_result_59, acc_valid_59, term_cnt_59, done_59
    );
endinterface

// File: rtl/fp16_acc_pipe.sv
// FP16 running-sum accumulator (MAC back-end): align/add/normalise over 4 FSM states, one product per 4 cycles.
// Define FP16_ACC_SAT_EN to saturate overflow to max finite; otherwise overflow yields signed infinity.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  S_IDLE  | waiting for a product (ready unless done or clearing)
//  S_ALIGN | order acc/product by magnitude, right-shift smaller sig
//  S_ADD   | add or subtract aligned significands
//  S_NORM  | normalise, truncate, write result, pulse acc_valid
module fp16_acc_pipe #(
    parameter int NUM_TERMS = 4,
    parameter int CNT_W     = 8
) (
    input logic            clk_59,
    input logic            reset_59,
    fp16_acc_pipe_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_ready;
    logic             w_accept;

    logic [15:0]      r_acc;
    logic [15:0]      r_prod;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic             r_big_sign;
    logic [4:0]       r_big_exp;
    logic [13:0]      r_big_sig;
    logic [13:0]      r_small_sig;
    logic             r_sub;
    logic [14:0]      r_sum;

    assign w_ready = (r_state == S_IDLE) && !r_done && !bus.clear_59;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid_59 && w_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ALIGN;
                end
            end
            S_ALIGN: w_state_nxt = S_ADD;
            S_ADD:   w_state_nxt = S_NORM;
            S_NORM:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Align: an exp==0 operand has zero magnitude and a zero significand, so it drops out of the sum.
    logic [4:0]  w_a_exp, w_b_exp;
    logic        w_a_zero, w_b_zero;
    logic [14:0] w_a_mag, w_b_mag;
    logic [13:0] w_a_sig, w_b_sig;
    logic        w_a_big;
    logic [4:0]  w_big_exp, w_small_exp, w_diff;
    logic [13:0] w_big_sig, w_small_sig, w_small_sh;

    assign w_a_exp     = r_acc[14:10];
    assign w_b_exp     = r_prod[14:10];
    assign w_a_zero    = (w_a_exp == 5'd0);
    assign w_b_zero    = (w_b_exp == 5'd0);
    assign w_a_mag     = {w_a_exp, (w_a_zero ? 10'd0 : r_acc[9:0])};
    assign w_b_mag     = {w_b_exp, (w_b_zero ? 10'd0 : r_prod[9:0])};
    assign w_a_sig     = w_a_zero ? 14'd0 : {1'b1, r_acc[9:0], 3'b000};
    assign w_b_sig     = w_b_zero ? 14'd0 : {1'b1, r_prod[9:0], 3'b000};
    assign w_a_big     = (w_a_mag >= w_b_mag);
    assign w_big_exp   = w_a_big ? w_a_exp : w_b_exp;
    assign w_small_exp = w_a_big ? w_b_exp : w_a_exp;
    assign w_big_sig   = w_a_big ? w_a_sig : w_b_sig;
    assign w_small_sig = w_a_big ? w_b_sig : w_a_sig;
    assign w_diff      = w_big_exp - w_small_exp;
    assign w_small_sh  = (w_diff > 5'd13) ? 14'd0 : (w_small_sig >> w_diff);

    // Normalise: exponent kept signed and wide so underflow/overflow are plain compares.
    logic [3:0]         w_lz;
    logic signed [6:0]  w_n_exp;
    logic [13:0]        w_n_sig;
    logic [15:0]        w_ovf;
    logic [15:0]        w_norm_res;

    always_comb begin
        w_lz = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (r_sum[i]) w_lz = 4'(13 - i);
        end
    end

    always_comb begin
        if (r_sum[14]) begin
            w_n_exp = 7'({2'b00, r_big_exp}) + 7'sd1;
            w_n_sig = r_sum[14:1];
        end else begin
            w_n_exp = 7'({2'b00, r_big_exp}) - 7'({3'b000, w_lz});
            w_n_sig = 14'(r_sum[13:0] << w_lz);
        end
    end

`ifdef FP16_ACC_SAT_EN
    assign w_ovf = {r_big_sign, 15'h7BFF};
`else
    assign w_ovf = {r_big_sign, 5'h1F, 10'h000};
`endif

    always_comb begin
        w_norm_res = {r_big_sign, 5'(w_n_exp), 10'(w_n_sig >> 3)};
        if (r_sum == 15'd0 || w_n_exp < 7'sd1) w_norm_res = 16'h0000;
        else if (w_n_exp > 7'sd30)             w_norm_res = w_ovf;
    end

    always_ff @(posedge clk_59) begin
        if (!reset_59 || bus.clear_59) begin
            r_state     <= S_IDLE;
            r_acc       <= 16'h0000;
            r_prod      <= 16'h0000;
            r_valid     <= 1'b0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_big_sign  <= 1'b0;
            r_big_exp   <= 5'd0;
            r_big_sig   <= 14'd0;
            r_small_sig <= 14'd0;
            r_sub       <= 1'b0;
            r_sum       <= 15'd0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= 1'b0;
            if (w_accept) begin
                r_prod <= bus.prod_59;
                r_cnt  <= r_cnt + 1'b1;
            end
            if (r_state == S_ALIGN) begin
                r_big_sign  <= w_a_big ? r_acc[15] : r_prod[15];
                r_big_exp   <= w_big_exp;
                r_big_sig   <= w_big_sig;
                r_small_sig <= w_small_sh;
                r_sub       <= r_acc[15] ^ r_prod[15];
            end
            if (r_state == S_ADD) begin
                r_sum <= r_sub ? ({1'b0, r_big_sig} - {1'b0, r_small_sig})
                               : ({1'b0, r_big_sig} + {1'b0, r_small_sig});
            end
            if (r_state == S_NORM) begin
                r_acc   <= w_norm_res;
                r_valid <= 1'b1;
                r_done  <= (r_cnt == CNT_W'(NUM_TERMS));
            end
        end
    end

    assign bus.in_ready_59   = w_ready;
    assign bus.acc_result_59 = r_acc;
    assign bus.acc_valid_59  = r_valid;
    assign bus.term_cnt_59   = r_cnt;
    assign bus.done_59       = r_done;

endmodule

// File: tb/tb_fp16_acc_pipe.sv
// Scoreboard bench for fp16_acc_pipe: driver queues hand-computed sums, a negedge monitor checks
// each acc_valid pulse for value and for the 3-edge latency from its accept edge.
module tb_fp16_acc_pipe;

    logic clk_59 = 1'b0;
    logic reset_59 = 1'b0;
    always #5 clk_59 = ~clk_59;

    fp16_acc_pipe_if #(.CNT_W(8)) bus();

    fp16_acc_pipe #(.NUM_TERMS(4), .CNT_W(8)) dut (
        .clk_59   (clk_59),
        .reset_59 (reset_59),
        .bus      (bus.slave)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [15:0] exp_q[$];
    int          acc_edge_q[$];
    logic [15:0] m_exp;
    int          m_edge;
    int          e0, e1, e2, e3;

`ifdef FP16_ACC_SAT_EN
    localparam logic [15:0] OVF_RES = 16'h7BFF;
`else
    localparam logic [15:0] OVF_RES = 16'h7C00;
`endif

    always @(posedge clk_59) cyc <= cyc + 1;

    always @(negedge clk_59) begin
        if (reset_59 && bus.in_valid_59 && bus.in_ready_59) acc_edge_q.push_back(cyc + 1);
        if (bus.acc_valid_59) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result act=%h req=none", bus.acc_result_59);
            end else begin
                m_exp = exp_q.pop_front();
                if (bus.acc_result_59 !== m_exp) begin
                    n_err++;
                    $display("FAIL acc_result act=%h req=%h", bus.acc_result_59, m_exp);
                end
            end
            if (acc_edge_q.size() > 0) begin
                m_edge = acc_edge_q.pop_front();
                n_vec++;
                if (cyc != m_edge + 3) begin
                    n_err++;
                    $display("FAIL latency act=%0d req=%0d", cyc - m_edge, 3);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_59);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s act=%h req=%h", nm, act, req);
        end
    endtask

    task automatic send(input logic [15:0] p, input logic [15:0] e, input bit push, output int edge_idx);
        int w;
        w = 0;
        edge_idx = -1;
        bus.prod_59     = p;
        bus.in_valid_59 = 1'b1;
        forever begin
            @(negedge clk_59);
            if (bus.in_ready_59) break;
            w++;
            if (w > 20) begin
                chk("accept_timeout", 32'd0, 32'd1);
                return;
            end
        end
        if (push) exp_q.push_back(e);
        edge_idx = cyc + 1;
        @(posedge clk_59);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 40) begin
            tick(1);
            w++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_clear();
        bus.clear_59 = 1'b1;
        tick(1);
        bus.clear_59 = 1'b0;
        acc_edge_q.delete();
        chk("clr_acc", 32'(bus.acc_result_59), 32'h0);
        chk("clr_cnt", 32'(bus.term_cnt_59), 32'd0);
        chk("clr_done", 32'(bus.done_59), 32'd0);
    endtask

    initial begin
        int dummy;
        bus.clear_59    = 1'b0;
        bus.in_valid_59 = 1'b0;
        bus.prod_59     = 16'h0000;
        tick(3);
        reset_59 = 1'b1;
        chk("rst_acc", 32'(bus.acc_result_59), 32'h0);
        chk("rst_valid", 32'(bus.acc_valid_59), 32'd0);
        chk("rst_cnt", 32'(bus.term_cnt_59), 32'd0);
        chk("rst_done", 32'(bus.done_59), 32'd0);
        chk("rst_ready", 32'(bus.in_ready_59), 32'd1);

        // valid held high through four back-to-back products
        send(16'h3C00, 16'h3C00, 1'b1, e0);
        send(16'h3C00, 16'h4000, 1'b1, e1);
        send(16'h3C00, 16'h4200, 1'b1, e2);
        send(16'h3C00, 16'h4400, 1'b1, e3);
        chk("spacing1", 32'(e1 - e0), 32'd4);
        chk("spacing2", 32'(e2 - e1), 32'd4);
        chk("spacing3", 32'(e3 - e2), 32'd4);
        drain();
        tick(2);
        chk("done_set", 32'(bus.done_59), 32'd1);
        chk("ready_after_done", 32'(bus.in_ready_59), 32'd0);
        chk("cnt_at_done", 32'(bus.term_cnt_59), 32'd4);
        tick(6);
        chk("cnt_held", 32'(bus.term_cnt_59), 32'd4);
        bus.in_valid_59 = 1'b0;

        // cancellation to +0, then a wide exponent gap
        do_clear();
        send(16'h4000, 16'h4000, 1'b1, dummy);
        send(16'hC000, 16'h0000, 1'b1, dummy);
        send(16'h6400, 16'h6400, 1'b1, dummy);
        send(16'h3C00, 16'h6401, 1'b1, dummy);
        drain();
        bus.in_valid_59 = 1'b0;

        // underflow flush, then overflow
        do_clear();
        send(16'h0400, 16'h0400, 1'b1, dummy);
        send(16'h8401, 16'h0000, 1'b1, dummy);
        send(16'h7BFF, 16'h7BFF, 1'b1, dummy);
        send(16'h7BFF, OVF_RES, 1'b1, dummy);
        drain();
        bus.in_valid_59 = 1'b0;

        // clear during ADD aborts the op and blocks acceptance that cycle
        do_clear();
        send(16'h3C00, 16'h0000, 1'b0, dummy);
        bus.in_valid_59 = 1'b0;
        tick(1);
        bus.clear_59    = 1'b1;
        bus.in_valid_59 = 1'b1;
        bus.prod_59     = 16'h3C00;
        #1;
        chk("ready_in_clear", 32'(bus.in_ready_59), 32'd0);
        @(posedge clk_59);
        #1;
        bus.clear_59    = 1'b0;
        bus.in_valid_59 = 1'b0;
        acc_edge_q.delete();
        chk("abort_acc", 32'(bus.acc_result_59), 32'h0);
        chk("abort_cnt", 32'(bus.term_cnt_59), 32'd0);
        chk("abort_valid", 32'(bus.acc_valid_59), 32'd0);
        tick(6);
        chk("abort_acc_late", 32'(bus.acc_result_59), 32'h0);

        // reset during NORM, then zero-exponent input and a sign-changing sum
        send(16'h3C00, 16'h3C00, 1'b1, dummy);
        bus.in_valid_59 = 1'b0;
        drain();
        send(16'h4000, 16'h0000, 1'b0, dummy);
        bus.in_valid_59 = 1'b0;
        tick(2);
        reset_59 = 1'b0;
        tick(1);
        reset_59 = 1'b1;
        acc_edge_q.delete();
        chk("rst_norm_acc", 32'(bus.acc_result_59), 32'h0);
        chk("rst_norm_cnt", 32'(bus.term_cnt_59), 32'd0);
        chk("rst_norm_valid", 32'(bus.acc_valid_59), 32'd0);
        send(16'h0001, 16'h0000, 1'b1, dummy);
        bus.in_valid_59 = 1'b0;
        drain();
        chk("zero_in_cnt", 32'(bus.term_cnt_59), 32'd1);
        send(16'h3C00, 16'h3C00, 1'b1, dummy);
        send(16'hC000, 16'hBC00, 1'b1, dummy);
        send(16'h0001, 16'hBC00, 1'b1, dummy);
        bus.in_valid_59 = 1'b0;
        drain();
        tick(2);
        chk("final_cnt", 32'(bus.term_cnt_59), 32'd4);
        chk("final_done", 32'(bus.done_59), 32'd1);
        tick(3);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
